alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked successor to the single-cycle 8-bit ALU. Accepts one operation per valid/ready transfer and registers the result with a full flag set (zero, carry, negative, overflow, error). Single-cycle ops take one clock. An optional iterative multiplier adds a multi-cycle op. Sits between the decode stage and writeback; both sides can stall.

## Interface
- `WIDTH`, 8, operand/result width (≥4).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept; transfer when `in_valid && in_ready`.
- `op`  in  4  opcode (see Operation).
- `a`, `b`  in  WIDTH  operands.
- `out_valid`  out  1  result registered and held.
- `out_ready`  in  1  consumer takes result; transfer when `out_valid && out_ready`.
- `ans`  out  WIDTH  result.
- `zero`, `carry`, `neg`, `ovf`, `err`  out  1 each  flags, all registered with `ans`.

## Operation
- Opcodes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101 (signed), SLTU 0110 (unsigned), BZ 0111 (`ans` = `a`==0 ? 1 : 0), SLL 1000, SRL 1001, SRA 1010, MUL 1011. All other codes are illegal.
- SLT/SLTU/BZ produce 1 or 0 zero-extended to WIDTH.
- Shifts use `b[$clog2(WIDTH)-1:0]` as the amount and ignore the upper bits of `b`.
- MUL returns the low WIDTH bits of the unsigned product.
- Arithmetic is modulo 2^WIDTH.
- `carry`: carry-out on ADD; borrow (`a` < `b` unsigned) on SUB; 0 for every other op.
- `ovf`: signed overflow on ADD/SUB; 0 otherwise.
- `zero` = (`ans` == 0) and `neg` = `ans[WIDTH-1]`, both updated for every op, including BZ.
- Illegal op: `ans` = 0, `err` = 1, `zero` = 1, other flags 0. The result still completes in one cycle through the normal handshake.
- FSM states:
  - IDLE: accepts ops. A single-cycle op loads the output register. MUL goes to MUL_RUN.
  - MUL_RUN: shift-add, one bit of `b` per cycle for WIDTH cycles, then loads the output register and returns to IDLE.
- Output register holds `ans` and all flags stable while `out_valid && !out_ready`.

## Timing
- Reset: `out_valid`=0, `ans`=0, all flags 0, FSM=IDLE, `in_ready`=0 while `rst` is high. Reset mid-MUL abandons the op with no output.
- `in_ready` = !rst && state==IDLE && (!out_valid || out_ready). It is combinational, so a drained result and a new accept can happen in the same edge.
- Single-cycle op: accepted at edge N, `out_valid`=1 after edge N. Back-to-back throughput is 1 op/clk when `out_ready` is held high.
- MUL: accepted at edge N, `out_valid`=1 after edge N+WIDTH. `in_ready`=0 throughout.
- `out_valid` clears on a consume edge unless a new result loads on the same edge.
- Inputs are sampled only on the accept edge; they may change freely afterwards.

## Configuration
- `ALU_MUL_EN` defined: MUL_RUN state and multiplier are present; MUL behaves as above.
- `ALU_MUL_EN` undefined: no multiplier logic and the FSM never leaves IDLE. MUL is treated as an illegal op (`err`=1, `ans`=0, 1-cycle).

## Structure
- `alu_pkg`: `alu_op_t` 4-bit enum of all opcodes and the FSM state typedef.
- Sub-module `alu_mul_iter`: start/done shift-add multiplier, WIDTH-parametrised. Instantiated only under `ALU_MUL_EN`.
- Top level holds the combinational datapath, flag logic, FSM and output register.

## Test plan
All scenarios use WIDTH=8.
- ADD a=0xFF, b=0x01 -> `ans`=0x00, `zero`=1, `carry`=1, `ovf`=0, one cycle after accept.
- SUB a=0x80, b=0x01 -> `ans`=0x7F, `ovf`=1, `carry`=0. SLT a=0xFF, b=0x01 -> `ans`=1. SLTU same operands -> `ans`=0.
- SRA a=0x90, b=0xF3 (amount 3) -> `ans`=0xF2, `neg`=1. Illegal op 1111 -> `ans`=0, `err`=1.
- `out_ready`=0 for 5 cycles after an ADD -> `ans`/flags stable, `in_ready`=0. Raise `out_ready` with a new op pending -> drain and accept on the same edge.
- MUL a=13, b=11 (`ALU_MUL_EN`) -> `ans`=0x8F after 8 cycles. Repeat with `rst` pulsed at cycle 4 -> no `out_valid`, `in_ready`=1 the cycle after `rst` falls.
- Stream 100 random ops with random `out_ready` -> results match the reference model in order, none lost or duplicated.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for alu_pipe: opcode enum, flag bundle and FSM state encoding.
// Opcode legality depends on the ALU_MUL_EN build macro.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'b0000,
    OpSub  = 4'b0001,
    OpAnd  = 4'b0010,
    OpOr   = 4'b0011,
    OpXor  = 4'b0100,
    OpSlt  = 4'b0101,
    OpSltu = 4'b0110,
    OpBz   = 4'b0111,
    OpSll  = 4'b1000,
    OpSrl  = 4'b1001,
    OpSra  = 4'b1010,
    OpMul  = 4'b1011
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
    logic err;
  } alu_flags_t;

  typedef logic [0:0] alu_state_t;

  localparam alu_state_t StIdle   = 1'b0;
  localparam alu_state_t StMulRun = 1'b1;

  // MUL is only a real opcode when the multiplier is built in.
  function automatic logic op_is_legal(logic [3:0] op);
`ifdef ALU_MUL_EN
    return op <= OpMul;
`else
    return op < OpMul;
`endif
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Decode-side request and writeback-side result channels of alu_pipe.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ans;
  logic             zero;
  logic             carry;
  logic             neg;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, ans, zero, carry, neg, ovf, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, ans, zero, carry, neg, ovf, err
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of the product.
// o_done pulses on the last iteration with o_product valid in that same cycle.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic             r_busy;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done     = r_busy && (r_cnt == LastCnt);
  // Final partial sum is forwarded so the result lands WIDTH edges after start.
  assign o_product  = w_acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CntW'(1);
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked WIDTH-bit ALU with a registered result and flag set.
// Build with ALU_MUL_EN defined to add the iterative MUL op; otherwise MUL decodes as illegal.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  alu_pipe_if.slave  bus
);

  localparam int unsigned ShW = $clog2(WIDTH);

  alu_state_t              r_state;
  alu_state_t              w_state_next;
  logic                    r_out_valid;
  logic [WIDTH-1:0]        r_ans;
  alu_flags_t              r_flags;

  logic                    w_accept;
  logic                    w_op_legal;
  logic                    w_is_mul;
  logic                    w_load;
  logic                    w_mul_done;
  logic [WIDTH-1:0]        w_mul_product;
  logic [WIDTH:0]          w_sum;
  logic [WIDTH:0]          w_diff;
  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic [ShW-1:0]          w_shamt;
  logic [WIDTH-1:0]        w_alu_ans;
  alu_flags_t              w_alu_flags;
  logic [WIDTH-1:0]        w_ld_ans;
  alu_flags_t              w_ld_flags;

  assign bus.in_ready = !rst && (r_state == StIdle) && (!r_out_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_op_legal   = op_is_legal(bus.op);
  assign w_is_mul     = w_op_legal && (bus.op == OpMul);

  assign w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff  = {1'b0, bus.a} - {1'b0, bus.b};
  assign w_a_s   = bus.a;
  assign w_b_s   = bus.b;
  assign w_shamt = bus.b[ShW-1:0];

  always_comb begin
    w_alu_ans   = '0;
    w_alu_flags = '0;
    case (bus.op)
      OpAdd: begin
        w_alu_ans         = w_sum[WIDTH-1:0];
        w_alu_flags.carry = w_sum[WIDTH];
        w_alu_flags.ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpSub: begin
        w_alu_ans         = w_diff[WIDTH-1:0];
        w_alu_flags.carry = w_diff[WIDTH];
        w_alu_flags.ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpAnd:  w_alu_ans = bus.a & bus.b;
      OpOr:   w_alu_ans = bus.a | bus.b;
      OpXor:  w_alu_ans = bus.a ^ bus.b;
      OpSlt:  w_alu_ans = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
      OpSltu: w_alu_ans = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OpBz:   w_alu_ans = {{(WIDTH-1){1'b0}}, (bus.a == '0)};
      OpSll:  w_alu_ans = bus.a << w_shamt;
      OpSrl:  w_alu_ans = bus.a >> w_shamt;
      OpSra:  w_alu_ans = w_a_s >>> w_shamt;
      // MUL also lands here, but its result is taken from the multiplier path instead.
      default: w_alu_flags.err = 1'b1;
    endcase
    w_alu_flags.zero = (w_alu_ans == '0);
    w_alu_flags.neg  = w_alu_ans[WIDTH-1];
  end

  always_comb begin
    w_ld_ans   = w_alu_ans;
    w_ld_flags = w_alu_flags;
    if (w_mul_done) begin
      w_ld_ans        = w_mul_product;
      w_ld_flags      = '0;
      w_ld_flags.zero = (w_mul_product == '0);
      w_ld_flags.neg  = w_mul_product[WIDTH-1];
    end
  end

  // Accept only happens in StIdle, so a single-cycle load never collides with w_mul_done.
  assign w_load = (w_accept && !w_is_mul) || w_mul_done;

  always_comb begin
    w_state_next = r_state;
    if (r_state == StIdle) begin
      if (w_accept && w_is_mul) begin
        w_state_next = StMulRun;
      end
    end else if (w_mul_done) begin
      w_state_next = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_out_valid <= 1'b0;
      r_ans       <= '0;
      r_flags     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_ans       <= w_ld_ans;
        r_flags     <= w_ld_flags;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_MUL_EN
  logic w_mul_start;

  assign w_mul_start = w_accept && w_is_mul;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_mul_start),
    .i_a      (bus.a),
    .i_b      (bus.b),
    .o_done   (w_mul_done),
    .o_product(w_mul_product)
  );
`else
  assign w_mul_done    = 1'b0;
  assign w_mul_product = '0;
`endif

  assign bus.out_valid = r_out_valid;
  assign bus.ans       = r_ans;
  assign bus.zero      = r_flags.zero;
  assign bus.carry     = r_flags.carry;
  assign bus.neg       = r_flags.neg;
  assign bus.ovf       = r_flags.ovf;
  assign bus.err       = r_flags.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8): directed corner cases plus a random stream vs a reference model.
`timescale 1ns/1ps
module tb_alu_pipe;

  localparam int W     = 8;
  localparam int NOps  = 100;

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpXor  = 4'h4;
  localparam logic [3:0] OpSlt  = 4'h5;
  localparam logic [3:0] OpSltu = 4'h6;
  localparam logic [3:0] OpBz   = 4'h7;
  localparam logic [3:0] OpSll  = 4'h8;
  localparam logic [3:0] OpSrl  = 4'h9;
  localparam logic [3:0] OpSra  = 4'hA;
  localparam logic [3:0] OpMul  = 4'hB;
  localparam logic [3:0] OpBad  = 4'hF;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {ans, zero, carry, neg, ovf, err}
  function automatic logic [12:0] dut_word();
    return {bus.ans, bus.zero, bus.carry, bus.neg, bus.ovf, bus.err};
  endfunction

  function automatic logic [12:0] model(input int op, input int a, input int b);
    int m, sa, sb, sh, r;
    logic c, o, e, z, n;
    logic [W-1:0] av;
    m  = 1 << W;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sh = b % W;
    r  = 0;
    c  = 1'b0;
    o  = 1'b0;
    e  = 1'b0;
    case (op)
      0: begin
        r = a + b;
        c = (r >= m);
        o = (sa + sb > m / 2 - 1) || (sa + sb < -(m / 2));
      end
      1: begin
        r = a - b;
        c = (a < b);
        o = (sa - sb > m / 2 - 1) || (sa - sb < -(m / 2));
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sa < sb) ? 1 : 0;
      6: r = (a < b) ? 1 : 0;
      7: r = (a == 0) ? 1 : 0;
      8: r = a * (1 << sh);
      9: r = a / (1 << sh);
      10: r = sa >>> sh;
`ifdef ALU_MUL_EN
      11: r = a * b;
`endif
      default: e = 1'b1;
    endcase
    r  = ((r % m) + m) % m;
    av = r[W-1:0];
    z  = (r == 0);
    n  = (r >= m / 2);
    return {av, z, c, n, o, e};
  endfunction

  // Entered at posedge+1; leaves at posedge+2 with in_ready checked.
  task automatic wait_ready(input string tag);
    int k = 0;
    #1;
    while (!bus.in_ready && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq({tag, "_in_ready"}, bus.in_ready, 1);
  endtask

  task automatic run_single(input string tag, input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [12:0] exp);
    bus.out_ready = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    wait_ready(tag);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    check_eq({tag, "_valid"}, bus.out_valid, 1);
    check_eq(tag, dut_word(), exp);
  endtask

  task automatic idle_cycle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

`ifdef ALU_MUL_EN
  task automatic start_mul(input string tag);
    bus.out_ready = 1'b1;
    bus.op        = OpMul;
    bus.a         = 8'd13;
    bus.b         = 8'd11;
    bus.in_valid  = 1'b1;
    wait_ready(tag);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] exp_word;
    logic [12:0] e;
    logic [12:0] exp_q[$];
    int sent, got, cyc, spurious;
    logic pend;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = 4'h0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_word", dut_word(), 13'h0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    #1;
    check_eq("rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    run_single("add_wrap",  OpAdd,  8'hFF, 8'h01, {8'h00, 5'b11000});
    run_single("sub_ovf",   OpSub,  8'h80, 8'h01, {8'h7F, 5'b00010});
    run_single("slt",       OpSlt,  8'hFF, 8'h01, {8'h01, 5'b00000});
    run_single("sltu",      OpSltu, 8'hFF, 8'h01, {8'h00, 5'b10000});
    run_single("sra",       OpSra,  8'h90, 8'hF3, {8'hF2, 5'b00100});
    run_single("illegal",   OpBad,  8'h12, 8'h34, {8'h00, 5'b10001});
    run_single("bz_zero",   OpBz,   8'h00, 8'h55, {8'h01, 5'b00000});
    run_single("xor_self",  OpXor,  8'hAA, 8'hAA, {8'h00, 5'b10000});
    run_single("sll_max",   OpSll,  8'h01, 8'h0F, {8'h80, 5'b00100});
    run_single("srl_hi_b",  OpSrl,  8'h80, 8'h09, {8'h40, 5'b00000});

    // Back-pressure: result must hold while out_ready is low.
    idle_cycle();
    bus.out_ready = 1'b0;
    bus.op        = OpAdd;
    bus.a         = 8'h7F;
    bus.b         = 8'h01;
    bus.in_valid  = 1'b1;
    wait_ready("stall_add");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_word     = {8'h80, 5'b00110};
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("stall_word_%0d", i), dut_word(), exp_word);
      check_eq($sformatf("stall_valid_%0d", i), bus.out_valid, 1);
      check_eq($sformatf("stall_in_ready_%0d", i), bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.op        = OpSub;
    bus.a         = 8'h05;
    bus.b         = 8'h07;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check_eq("drain_accept_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("drain_accept_valid", bus.out_valid, 1);
    check_eq("drain_accept_word", dut_word(), {8'hFE, 5'b01100});
    idle_cycle();

`ifdef ALU_MUL_EN
    begin
      int first;
      int rdy_bad;
      logic [12:0] w_seen;
      first   = -1;
      rdy_bad = 0;
      w_seen  = '0;
      start_mul("mul");
      for (int c = 0; c <= 2 * W && first < 0; c++) begin
        if (bus.out_valid) begin
          first  = c;
          w_seen = dut_word();
        end else begin
          if (bus.in_ready) rdy_bad++;
          @(posedge clk);
          #1;
        end
      end
      check_eq("mul_latency", first, W);
      check_eq("mul_in_ready_busy", rdy_bad, 0);
      check_eq("mul_result", w_seen, {8'h8F, 5'b00100});
      idle_cycle();

      start_mul("mul_rst");
      repeat (3) begin
        @(posedge clk);
        #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_eq("mul_rst_in_ready", bus.in_ready, 1);
      spurious = 0;
      for (int c = 0; c < 2 * W; c++) begin
        if (bus.out_valid) spurious++;
        @(posedge clk);
        #1;
      end
      check_eq("mul_rst_no_output", spurious, 0);
    end
`else
    run_single("mul_illegal", OpMul, 8'd13, 8'd11, {8'h00, 5'b10001});
    idle_cycle();
`endif

    // Random stream with random back-pressure, scored in order.
    sent = 0;
    got  = 0;
    cyc  = 0;
    pend = 1'b0;
    while (got < NOps && cyc < 5000) begin
      if (!pend && sent < NOps && $urandom_range(0, 3) != 0) begin
        bus.op = 4'($urandom_range(0, 15));
        bus.a  = 8'($urandom);
        bus.b  = 8'($urandom);
        pend   = 1'b1;
      end
      bus.in_valid  = pend;
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("stream_spurious_out", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_eq($sformatf("stream_%0d", got), dut_word(), e);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(int'(bus.op), int'(bus.a), int'(bus.b)));
        sent++;
        pend = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("stream_sent", sent, NOps);
    check_eq("stream_got", got, NOps);
    check_eq("stream_leftover", exp_q.size(), 0);
    idle_cycle();
    idle_cycle();
    check_eq("stream_no_extra", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
